// File: rtl/ga_pe_sequencer_if.sv
//------------------------------------------------------------------------------
// ga_pe_sequencer_if : bus bundle between the sequencer, the buffer and the PE
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ga_pe_sequencer_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W-1:0] num_children;
  logic             cfg_we;
  logic [7:0]       cfg_co_prob;
  logic [7:0]       cfg_perturb_prob;
  logic             cfg_bias;
  logic             par_valid;
  logic             par_ready;
  logic [31:0]      par_gene0;
  logic [31:0]      par_gene1;
  logic [31:0]      pe_parent_gene0;
  logic [31:0]      pe_parent_gene1;
  logic [7:0]       pe_co_prob;
  logic [7:0]       pe_perturb_prob;
  logic             pe_bias;
  logic [31:0]      pe_child_gene;
  logic             child_valid;
  logic [31:0]      child_gene;
  logic [IDX_W-1:0] child_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start, num_children, cfg_we, cfg_co_prob, cfg_perturb_prob, cfg_bias,
    input  par_valid, par_gene0, par_gene1, pe_child_gene,
    output par_ready, pe_parent_gene0, pe_parent_gene1, pe_co_prob, pe_perturb_prob,
    output pe_bias, child_valid, child_gene, child_idx, busy, done
  );

  modport slave (
    output start, num_children, cfg_we, cfg_co_prob, cfg_perturb_prob, cfg_bias,
    output par_valid, par_gene0, par_gene1, pe_child_gene,
    input  par_ready, pe_parent_gene0, pe_parent_gene1, pe_co_prob, pe_perturb_prob,
    input  pe_bias, child_valid, child_gene, child_idx, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/ga_pe_sequencer.sv
//------------------------------------------------------------------------------
// ga_pe_sequencer : issues parent pairs into a fixed-latency PE, tags children
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ga_pe_sequencer #(
  parameter int PE_LAT = 3,
  parameter int IDX_W  = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ga_pe_sequencer_if.master  bus
);

  localparam logic [IDX_W-1:0] c_IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] c_IDX_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDX_W-1:0] r_num;
  logic [IDX_W-1:0] r_issued;
  logic [IDX_W-1:0] r_received;

  logic [PE_LAT:0]  r_tok_vld;
  logic [IDX_W-1:0] r_tok_idx [PE_LAT+1];

  logic [31:0]      r_par0;
  logic [31:0]      r_par1;
  logic [7:0]       r_co;
  logic [7:0]       r_pert;
  logic             r_bias;

  logic             w_par_ready;
  logic             w_xfer;
  logic             w_start_ok;
  logic             w_last_issue;
  logic             w_pipe_empty;
  logic             w_child_valid;
  logic             w_all_received;
  logic             w_busy;
  logic             w_done;

  assign w_par_ready   = (r_state == ST_RUN);
  assign w_xfer        = bus.par_valid & w_par_ready;
  assign w_start_ok    = (r_state == ST_IDLE) & bus.start;
  assign w_last_issue  = (r_issued == (r_num - c_IDX_ONE));
  assign w_child_valid = r_tok_vld[PE_LAT];
  // Tokens still upstream of the output slot; the leaving token counts as received.
  assign w_pipe_empty  = ~|r_tok_vld[PE_LAT-1:0];
  assign w_all_received = w_child_valid ? ((r_received + c_IDX_ONE) == r_num)
                                        : (r_received == r_num);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = (bus.num_children == c_IDX_ZERO) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_xfer && w_last_issue) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pipe_empty && w_all_received) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num      <= '0;
      r_issued   <= '0;
      r_received <= '0;
    end else if (w_start_ok) begin
      r_num      <= bus.num_children;
      r_issued   <= '0;
      r_received <= '0;
    end else begin
      if (w_xfer) begin
        r_issued <= r_issued + c_IDX_ONE;
      end
      if (w_child_valid) begin
        r_received <= r_received + c_IDX_ONE;
      end
    end
  end

  // Token line mirrors the PE pipeline; idle cycles push empty tokens.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tok_vld <= '0;
      for (int i = 0; i <= PE_LAT; i++) begin
        r_tok_idx[i] <= '0;
      end
    end else begin
      r_tok_vld    <= {r_tok_vld[PE_LAT-1:0], w_xfer};
      r_tok_idx[0] <= w_xfer ? r_issued : c_IDX_ZERO;
      for (int i = 1; i <= PE_LAT; i++) begin
        r_tok_idx[i] <= r_tok_idx[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par0 <= '0;
      r_par1 <= '0;
    end else if (w_xfer) begin
      r_par0 <= bus.par_gene0;
      r_par1 <= bus.par_gene1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_co   <= 8'h80;
      r_pert <= 8'h10;
      r_bias <= 1'b0;
    end else if (bus.cfg_we && (r_state == ST_IDLE)) begin
      r_co   <= bus.cfg_co_prob;
      r_pert <= bus.cfg_perturb_prob;
      r_bias <= bus.cfg_bias;
    end
  end

  assign bus.par_ready       = w_par_ready;
  assign bus.pe_parent_gene0 = r_par0;
  assign bus.pe_parent_gene1 = r_par1;
  assign bus.pe_co_prob      = r_co;
  assign bus.pe_perturb_prob = r_pert;
  assign bus.pe_bias         = r_bias;
  assign bus.child_valid     = w_child_valid;
  assign bus.child_gene      = bus.pe_child_gene;
  assign bus.child_idx       = r_tok_idx[PE_LAT];
  assign bus.busy            = w_busy;
  assign bus.done            = w_done;

endmodule

`default_nettype wire

// File: tb/tb_ga_pe_sequencer.sv
//------------------------------------------------------------------------------
// tb_ga_pe_sequencer : directed scoreboard bench for ga_pe_sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ga_pe_sequencer;

  localparam int PE_LAT = 3;
  localparam int IDX_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ga_pe_sequencer_if #(.IDX_W(IDX_W)) bus ();

  ga_pe_sequencer #(.PE_LAT(PE_LAT), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PE model: XOR of the registered parents, three further register stages.
  logic [31:0] pe_p1 = '0;
  logic [31:0] pe_p2 = '0;
  logic [31:0] pe_p3 = '0;
  always @(posedge clk) begin
    pe_p1 <= bus.pe_parent_gene0 ^ bus.pe_parent_gene1;
    pe_p2 <= pe_p1;
    pe_p3 <= pe_p2;
  end
  assign bus.pe_child_gene = pe_p3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      gene;
    logic [31:0]      cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  int               n_cmp = 0;
  int               n_err = 0;
  int               child_cnt = 0;
  int               done_cnt = 0;
  int               last_child_cyc = 0;
  bit               ready_seen = 1'b0;
  logic [IDX_W-1:0] exp_idx = '0;
  int               c0, d0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.par_ready === 1'b1) ready_seen = 1'b1;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.child_valid === 1'b1) begin
      child_cnt++;
      last_child_cyc = cyc;
      if (sb.size() == 0) begin
        chk("spurious_child", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("child_idx", 64'(bus.child_idx), 64'(e.idx));
        chk("child_gene", 64'(bus.child_gene), 64'(e.gene));
        chk("child_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drive(input logic v);
    logic [31:0] g0, g1;
    g0 = $urandom;
    g1 = $urandom;
    bus.par_valid = v;
    bus.par_gene0 = g0;
    bus.par_gene1 = g1;
    #1;
    if (v && bus.par_ready && !rst) begin
      sb.push_back('{idx: exp_idx, gene: g0 ^ g1, cyc: 32'(cyc + PE_LAT + 1)});
      exp_idx++;
    end
    @(negedge clk);
  endtask

  task automatic do_start(input logic [IDX_W-1:0] n);
    bus.start        = 1'b1;
    bus.num_children = n;
    exp_idx          = '0;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.num_children = ~n;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 64'(bus.done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;  bus.num_children = '0;
    bus.cfg_we = 1'b0; bus.cfg_co_prob = '0; bus.cfg_perturb_prob = '0; bus.cfg_bias = 1'b0;
    bus.par_valid = 1'b0; bus.par_gene0 = '0; bus.par_gene1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_par_ready", 64'(bus.par_ready), 64'd0);
    chk("rst_child_valid", 64'(bus.child_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_child_idx", 64'(bus.child_idx), 64'd0);
    chk("rst_parent0", 64'(bus.pe_parent_gene0), 64'd0);
    chk("rst_parent1", 64'(bus.pe_parent_gene1), 64'd0);
    chk("rst_co", 64'(bus.pe_co_prob), 64'h80);
    chk("rst_pert", 64'(bus.pe_perturb_prob), 64'h10);
    chk("rst_bias", 64'(bus.pe_bias), 64'd0);

    bus.cfg_we = 1'b1; bus.cfg_co_prob = 8'h40; bus.cfg_perturb_prob = 8'h05; bus.cfg_bias = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    chk("cfg_co", 64'(bus.pe_co_prob), 64'h40);
    chk("cfg_pert", 64'(bus.pe_perturb_prob), 64'h05);
    chk("cfg_bias", 64'(bus.pe_bias), 64'd1);

    // Generation of 4 with continuous parents and a config write during RUN.
    c0 = child_cnt; d0 = done_cnt;
    do_start(8'd4);
    chk("a_busy", 64'(bus.busy), 64'd1);
    chk("a_ready", 64'(bus.par_ready), 64'd1);
    bus.cfg_we = 1'b1; bus.cfg_co_prob = 8'hFF; bus.cfg_perturb_prob = 8'hEE; bus.cfg_bias = 1'b0;
    for (int i = 0; i < 20 && exp_idx < 4; i++) drive(1'b1);
    bus.par_valid = 1'b0;
    bus.cfg_we = 1'b0;
    chk("a_ready_drop", 64'(bus.par_ready), 64'd0);
    chk("a_cfg_co_hold", 64'(bus.pe_co_prob), 64'h40);
    chk("a_cfg_pert_hold", 64'(bus.pe_perturb_prob), 64'h05);
    chk("a_cfg_bias_hold", 64'(bus.pe_bias), 64'd1);
    wait_done("a");
    chk("a_done_lat", 64'(cyc), 64'(last_child_cyc + 1));
    @(negedge clk);
    chk("a_done_pulse", 64'(bus.done), 64'd0);
    chk("a_idle", 64'(bus.busy), 64'd0);
    chk("a_children", 64'(child_cnt - c0), 64'd4);
    chk("a_dones", 64'(done_cnt - d0), 64'd1);
    chk("a_sb_empty", 64'(sb.size()), 64'd0);

    // Generation of 3 with gaps in the parent stream.
    c0 = child_cnt;
    do_start(8'd3);
    for (int i = 0; i < 5; i++) drive((i % 2) == 0);
    bus.par_valid = 1'b0;
    wait_done("b");
    chk("b_done_lat", 64'(cyc), 64'(last_child_cyc + 1));
    @(negedge clk);
    chk("b_children", 64'(child_cnt - c0), 64'd3);
    chk("b_sb_empty", 64'(sb.size()), 64'd0);

    // Empty generation.
    c0 = child_cnt; d0 = done_cnt; ready_seen = 1'b0;
    do_start(8'd0);
    chk("z_done", 64'(bus.done), 64'd1);
    chk("z_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("z_done_pulse", 64'(bus.done), 64'd0);
    chk("z_idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("z_no_ready", 64'(ready_seen), 64'd0);
    chk("z_no_child", 64'(child_cnt - c0), 64'd0);
    chk("z_dones", 64'(done_cnt - d0), 64'd1);

    // Reset two cycles after the first transfer of an 8-child generation.
    do_start(8'd8);
    drive(1'b1);
    drive(1'b1);
    rst = 1'b1;
    sb.delete();
    c0 = child_cnt; d0 = done_cnt;
    drive(1'b1);
    rst = 1'b0;
    bus.par_valid = 1'b0;
    chk("r_busy", 64'(bus.busy), 64'd0);
    chk("r_ready", 64'(bus.par_ready), 64'd0);
    repeat (8) @(negedge clk);
    chk("r_no_child", 64'(child_cnt - c0), 64'd0);
    chk("r_no_done", 64'(done_cnt - d0), 64'd0);

    c0 = child_cnt;
    do_start(8'd2);
    for (int i = 0; i < 20 && exp_idx < 2; i++) drive(1'b1);
    bus.par_valid = 1'b0;
    wait_done("p");
    chk("p_done_lat", 64'(cyc), 64'(last_child_cyc + 1));
    @(negedge clk);
    chk("p_children", 64'(child_cnt - c0), 64'd2);
    chk("p_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ga_pe_sequencer.md
# ga_pe_sequencer

Generation sequencer for a single crossover/perturb processing element (PE). Accepts a start command and a child count, pulls parent-gene pairs from an upstream valid/ready source, and drives them into the PE at up to one pair per cycle. It holds the PE probability and bias configuration, tracks in-flight pairs through the PE's fixed pipeline latency, and emits each child gene tagged with its index. It sits between the population buffer (parent fetch / child write-back) and the PE datapath.

## Interface
- PE_LAT, 3: PE latency in cycles from a registered parent input to a valid child_gene; must be ≥1.
- IDX_W, 8: width of the child count and child index.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a generation; sampled only in IDLE.
- num_children  in  IDX_W  children to produce this generation; sampled with start.
- cfg_we  in  1  configuration write strobe; honoured only in IDLE.
- cfg_co_prob  in  8  crossover probability to load.
- cfg_perturb_prob  in  8  perturbation probability to load.
- cfg_bias  in  1  crossover bias to load.
- par_valid  in  1  parent pair available.
- par_ready  out  1  sequencer accepts a parent pair.
- par_gene0, par_gene1  in  32 each  parent genes.
- pe_parent_gene0, pe_parent_gene1  out  32 each  registered parent genes to the PE.
- pe_co_prob, pe_perturb_prob  out  8 each  configuration to the PE.
- pe_bias  out  1  bias to the PE.
- pe_child_gene  in  32  child gene from the PE.
- child_valid  out  1  child_gene and child_idx are valid this cycle.
- child_gene  out  32  child gene; passed through from pe_child_gene.
- child_idx  out  IDX_W  index of this child, 0..num_children-1, in issue order.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at end of generation.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start when num_children ≠ 0.
  - IDLE → DONE on start when num_children = 0.
  - RUN → DRAIN on the cycle the final pair is accepted.
  - DRAIN → DONE when no tokens are in flight and the received count equals num_children.
  - DONE → IDLE unconditionally. done = 1 only while in DONE.
- par_ready = 1 only in RUN. It is combinational from state.
- A transfer occurs when par_valid & par_ready. On each transfer:
  - Capture par_gene0/1 into pe_parent_gene0/1.
  - Push a token {valid, idx = issued_count} into a PE_LAT+1 deep shift register.
  - Increment issued_count.
- Without a transfer, pe_parent_gene0/1 hold their value and a zero token is shifted in. PE output from such cycles is ignored.
- child_valid = valid bit of the token leaving the shift register.
  - child_idx = that token's idx.
  - child_gene = pe_child_gene, combinational pass-through.
  - received_count increments on each child_valid.
- There is no output backpressure. The sink must accept a child every cycle.
- Configuration registers drive pe_co_prob, pe_perturb_prob and pe_bias.
  - They are written on cfg_we in IDLE.
  - They stay stable for the whole generation. cfg_we outside IDLE is ignored.
- start outside IDLE is ignored.
- num_children is latched on the accepted start. Later changes have no effect until the next generation.
- issued_count and received_count are IDX_W wide and cleared on leaving IDLE. They never wrap, because issued_count ≤ num_children.

## Timing
- Reset values:
  - state IDLE; par_ready, child_valid, busy, done = 0.
  - child_idx = 0; pe_parent_gene0/1 = 0; all tokens cleared.
  - pe_co_prob = 8'h80, pe_perturb_prob = 8'h10, pe_bias = 0.
- rst mid-generation: next cycle is IDLE and all in-flight tokens are discarded. No child_valid and no done pulse follow.
- start accepted at edge t: busy = 1 and par_ready = 1 from cycle t+1 (RUN).
- Latency: a transfer at edge t gives child_valid high during cycle t+PE_LAT+1 (4 cycles for the default).
- Throughput: one child per cycle with continuous par_valid.
- Final transfer at edge t: par_ready = 0 from cycle t+1. The last child_valid is in cycle t+PE_LAT+1, DONE (done = 1) is in cycle t+PE_LAT+2, and IDLE follows the next cycle.
- num_children = 0: start at edge t gives done = 1 in cycle t+1, then IDLE. There is no child_valid.

## Test plan
- Reset, then check: all outputs at their reset values, pe_co_prob = 0x80, pe_perturb_prob = 0x10, busy = 0.
- cfg_we in IDLE with co = 0x40, pert = 0x05, bias = 1 → PE outputs reflect these next cycle. cfg_we during RUN with other values → no change.
- num_children = 4 with par_valid held high, PE model = 4-cycle delay line (parent0 XOR parent1) → child_valid in 4 consecutive cycles with idx 0,1,2,3 and correct genes. done asserts exactly one cycle after the last child.
- num_children = 3 with par_valid toggled 1,0,1,0,1 → children keep issue order and idx 0..2, with gaps matching the input gaps. No spurious child_valid.
- num_children = 0 → done pulse one cycle after start, no child_valid, par_ready never high.
- Assert rst two cycles after the first transfer of an 8-child generation → IDLE next cycle, no further child_valid or done. A subsequent start behaves normally.
